clk_gen_param: RTL
==================

Name: clk_gen_param

Overview:
Parametrised successor to the fixed clk16f to clk4f/clk2f/clkf divider.
- Derives N_OUT power-of-two divided clocks from clk16f.
- Adds per-output pre-edge strobes, a glitch-free run/stop gate that always stops on a full slow-clock period boundary, a synchronous phase realign, and a ready flag.
- Sits at the top of the data-path clock tree, feeding the lane/serialiser blocks.

Parameters:
- BASE, 2, log2 of the divide ratio of clk_div[0] (BASE >= 1); default gives /4.
- N_OUT, 3, number of divided outputs; clk_div[i] divides by 2^(BASE+i); default gives /4, /8, /16.
- CW, BASE+N_OUT-1, derived counter width; must not be overridden.

Ports:
- clk16f  input  1  fast source clock; all logic on its posedge.
- reset_L  input  1  asynchronous, active-low reset.
- en  input  1  run request; 1 = run, 0 = stop at the next slow-period boundary.
- sync_clr  input  1  synchronous phase realign; clears the counter.
- clk_div  output  N_OUT  divided clocks; bit i = clk16f / 2^(BASE+i), 50% duty.
- rise_stb  output  N_OUT  bit i high for exactly the one clk16f cycle immediately before clk_div[i] rises.
- ready  output  1  high once a full period of clk_div[N_OUT-1] has completed since the last start, clear or reset.

Behaviour:
- State: CW-bit counter cnt, FSM {STOPPED, RUN, STOP_PEND}, ready flop.
- Reset (reset_L=0, async): cnt=0, state=STOPPED, ready=0. Therefore clk_div=0 and rise_stb=0.
- clk_div[i] = cnt[BASE+i-1]. Each output is a single flop bit, so glitch-free; no combinational clock gating.
- rise_stb[i] = (state != STOPPED) && (cnt[BASE+i-1:0] == 2^(BASE+i-1)-1). This is a decode of registered state.
- STOPPED:
  - cnt held at 0.
  - en=1 at an edge -> RUN. cnt stays 0 on that edge; counting starts on the next edge.
- RUN:
  - cnt increments mod 2^CW every edge.
  - en=0 -> STOP_PEND; cnt still increments on that edge.
- STOP_PEND:
  - cnt keeps incrementing.
  - en=1 -> RUN, with no phase disturbance.
  - cnt wraps from 2^CW-1 to 0 -> STOPPED; all outputs are low from that edge.
  - en=1 on the wrap edge -> RUN (the wrap does not stop the block).
- ready:
  - Set on the edge where cnt wraps 2^CW-1 -> 0 while in RUN.
  - Cleared on entry to STOPPED and on sync_clr.
  - Otherwise holds.
- sync_clr=1 at an edge:
  - cnt <- 0 and ready <- 0.
  - In STOP_PEND it counts as the wrap -> STOPPED, unless en=1, in which case -> RUN.
  - In STOPPED it has no effect beyond the clears.
  - In RUN, state is unchanged.
- Priority: reset_L > sync_clr > en > counting.
- Simultaneous edges of different outputs are inherent and aligned: every clk_div[j] with j>i rises only on an edge where clk_div[i] also toggles.
- Reset mid-operation: immediate async return to the reset values; restart needs en=1.
- Width rule: cnt is an unsigned CW-bit value; wrap is natural overflow, with no saturation.

Decomposition:
- Shared package clk_gen_pkg holds:
  - the FSM state encoding (2-bit localparams STOPPED=0, RUN=1, STOP_PEND=2);
  - a helper constant function for CW.
- No sub-module: one counter/FSM sequential block plus generate-loop decodes for clk_div and rise_stb.
- The existing behavioural/structural pair pattern applies. A synthesised structural netlist is checked against the behavioural RTL bit-for-bit by the same probador.

Test Plan:
1. Defaults (BASE=2, N_OUT=3); release reset with en=1.
   - Edge 1 -> RUN, cnt=0.
   - clk_div[0] first rises at edge 3 (period 4); clk_div[1] at edge 5 (period 8); clk_div[2] at edge 9 (period 16).
   - ready rises at edge 17.
2. Same setup, check strobes.
   - rise_stb[0] high when cnt in {1,5,9,13}.
   - rise_stb[1] high when cnt in {3,11}.
   - rise_stb[2] high only when cnt=7.
   - Each strobe lasts exactly one cycle.
3. en dropped when cnt=5.
   - Counting continues through 15; the next edge gives cnt=0 and STOPPED.
   - clk_div=000, rise_stb=000, ready=0.
   - en raised again: one idle edge, then clk_div[0] rises after 2 more edges.
4. en pulsed low 3 cycles starting at cnt=4.
   - No stop occurs (STOP_PEND -> RUN).
   - clk_div waveforms are identical to an uninterrupted run; ready stays 1.
5. sync_clr at cnt=9 in RUN.
   - Next edge: cnt=0, clk_div=000, ready=0.
   - ready re-asserts exactly 16 edges later.
6. reset_L asserted asynchronously mid-cycle at cnt=11.
   - Outputs go 0 immediately, without waiting for a clk16f edge.
   - Separately, rerun scenario 1 with BASE=1, N_OUT=5: the divided outputs have periods 2, 4, 8, 16, 32; rise_stb stays 0 during reset.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared definitions for the clk16f power-of-two clock divider.
// Holds the run/stop FSM state encoding and the counter-width helper.
// Imported by clk_gen_param and by anything that needs to decode its state.
package clk_gen_pkg;

    // Run/stop controller states (2-bit encoding).
    typedef enum logic [1:0] {
        STOPPED   = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    // Counter width needed to reach the slowest output: the top counter bit
    // drives the clk16f / 2^(base+n_out-1) output.
    function automatic int calc_cw(input int base, input int n_out);
        return base + n_out - 1;
    endfunction

endpackage

// File: rtl/clk_gen_param.sv
// clk_gen_param: derives N_OUT power-of-two divided clocks from clk16f, plus
// per-output pre-rise strobes, a run/stop gate that only stops on a full
// slow-clock period boundary, a synchronous phase realign and a ready flag.
// Ports: clk16f (source clock, posedge), reset_L (async active-low reset),
//        en (run request), sync_clr (clear counter/ready),
//        clk_div[i] = clk16f / 2^(BASE+i) at 50% duty,
//        rise_stb[i] = high the one clk16f cycle before clk_div[i] rises,
//        ready = a full period of the slowest output completed since start/clear.
module clk_gen_param
    import clk_gen_pkg::*;
#(
    parameter int BASE  = 2,   // log2 of the divide ratio of clk_div[0], >= 1
    parameter int N_OUT = 3    // number of divided outputs
) (
    input  logic             clk16f,
    input  logic             reset_L,
    input  logic             en,
    input  logic             sync_clr,
    output logic [N_OUT-1:0] clk_div,
    output logic [N_OUT-1:0] rise_stb,
    output logic             ready
);

    // Derived internally so it can never disagree with BASE/N_OUT.
    localparam int CW = calc_cw(BASE, N_OUT);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ready_nxt;
    logic          wrap;

    // Last count of a slowest-clock period; the following edge is the boundary.
    assign wrap = (cnt == {CW{1'b1}});

    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            state <= STOPPED;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = ready;

        if (sync_clr) begin
            // Realign: the counter restarts from zero.  A pending stop treats
            // the clear as its period boundary; a running block keeps running.
            cnt_nxt   = '0;
            ready_nxt = 1'b0;
            case (state)
                STOPPED:   if (en) state_nxt = RUN;
                STOP_PEND: state_nxt = en ? RUN : STOPPED;
                default:   state_nxt = state;
            endcase
        end else begin
            case (state)
                STOPPED: begin
                    // Counter held at zero; the start edge itself does not count.
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                    if (en) state_nxt = RUN;
                end
                RUN: begin
                    cnt_nxt = cnt + CW'(1);
                    if (wrap) ready_nxt = 1'b1;
                    if (!en)  state_nxt = STOP_PEND;
                end
                STOP_PEND: begin
                    // Keep counting so the stop lands on a full slow period.
                    // A renewed run request, even on the wrap edge, cancels it
                    // without disturbing phase.
                    cnt_nxt = cnt + CW'(1);
                    if (en) begin
                        state_nxt = RUN;
                    end else if (wrap) begin
                        state_nxt = STOPPED;
                        ready_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = STOPPED;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end
            endcase
        end
    end

    // Each divided clock is a counter flop bit, so it is glitch-free.  The
    // strobe decodes the count just before that bit goes 0 -> 1: low bits
    // all ones with the output bit itself still clear.
    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        localparam logic [CW-1:0] MASK = CW'((64'd1 << (BASE + i)) - 64'd1);
        localparam logic [CW-1:0] PRE  = CW'((64'd1 << (BASE + i - 1)) - 64'd1);

        assign clk_div[i]  = cnt[BASE+i-1];
        assign rise_stb[i] = (state != STOPPED) && ((cnt & MASK) == PRE);
    end

endmodule
